// File: rtl/output_compare_wgen.sv
// Output-compare / waveform generator fed by the timer counter.
// Produces the compare pin, a one-cycle match strobe and a double-buffered OCR.
//
// state | meaning
// IDLE  | waveform parked at IDLE_LEVEL, counter history tracked
// RUN   | toggle (01) or fast-PWM (10) generation
// ARMED | single-shot waiting for its first match
// DONE  | single-shot fired, level held until disabled
module output_compare_wgen #(
    parameter int   WIDTH      = 16,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             i_sysclk,
    input  logic             i_sysrst,
    input  logic             i_en,
    input  logic [1:0]       i_mode,
    input  logic             i_inv,
    input  logic             i_force,
    input  logic             i_ocr_wr,
    input  logic [WIDTH-1:0] i_ocr_data,
    input  logic [WIDTH-1:0] i_cnt,
    output logic             o_cout_pin,
    output logic             o_ocm_flg,
    output logic [WIDTH-1:0] o_ocr_act,
    output logic             o_busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_ARMED = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] M_OFF     = 2'b00;
    localparam logic [1:0] M_PWM     = 2'b10;
    localparam logic [1:0] M_ONESHOT = 2'b11;

    logic [1:0]       state, state_nx;
    logic [1:0]       mode_q;
    logic             wave, wave_nx;
    logic             flg_nx;
    logic [WIDTH-1:0] ocr_buf, ocr_act, cnt_q;
    logic             pend;
    logic             match, bottom, hit, leave, xfer;

    // Edge-qualified compare: a counter parked on the compare value fires once.
    assign match  = (i_cnt == ocr_act) && (i_cnt != cnt_q);
    assign bottom = (i_cnt == '0) && (cnt_q != '0);
    assign hit    = match || i_force;
    assign leave  = !i_en || (i_mode == M_OFF) || ((state != S_IDLE) && (i_mode != mode_q));
    assign xfer   = pend && ((i_mode != M_PWM) || bottom);

    always_comb begin
        state_nx = state;
        wave_nx  = wave;
        flg_nx   = 1'b0;
        if (leave) begin
            state_nx = S_IDLE;
            wave_nx  = IDLE_LEVEL;
        end else begin
            case (state)
                S_IDLE: begin
                    wave_nx  = IDLE_LEVEL;
                    state_nx = (i_mode == M_ONESHOT) ? S_ARMED : S_RUN;
                end
                S_RUN: begin
                    flg_nx = match;
                    if (mode_q == M_PWM) begin
                        // Clear beats set so OCR=0 yields a constant low.
                        if (hit)
                            wave_nx = 1'b0;
                        else if (bottom)
                            wave_nx = 1'b1;
                    end else if (hit) begin
                        wave_nx = !wave;
                    end
                end
                S_ARMED: begin
                    flg_nx = match;
                    if (hit) begin
                        wave_nx  = 1'b1;
                        state_nx = S_DONE;
                    end
                end
                default: begin
                    state_nx = S_DONE;
                end
            endcase
        end
    end

    always_ff @(posedge i_sysclk or posedge i_sysrst) begin
        if (i_sysrst) begin
            state     <= S_IDLE;
            mode_q    <= M_OFF;
            wave      <= IDLE_LEVEL;
            o_ocm_flg <= 1'b0;
            ocr_buf   <= '0;
            ocr_act   <= '0;
            pend      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state     <= state_nx;
            mode_q    <= i_mode;
            wave      <= wave_nx;
            o_ocm_flg <= flg_nx;
            cnt_q     <= i_cnt;
            if (i_ocr_wr)
                ocr_buf <= i_ocr_data;
            if (xfer)
                ocr_act <= ocr_buf;
            // A write landing on a transfer edge stays pending for the next one.
            if (i_ocr_wr)
                pend <= 1'b1;
            else if (xfer)
                pend <= 1'b0;
        end
    end

    assign o_cout_pin = wave ^ i_inv;
    assign o_ocr_act  = ocr_act;
    assign o_busy     = (state == S_RUN) || (state == S_ARMED);

endmodule

// File: tb/tb_output_compare_wgen.sv
// Directed bench for output_compare_wgen: toggle, fast-PWM, single-shot,
// force, OCR buffering and async reset, with hand-derived expectations.
module tb_output_compare_wgen;

    logic        i_sysclk = 1'b0;
    logic        i_sysrst;
    logic        i_en;
    logic [1:0]  i_mode;
    logic        i_inv;
    logic        i_force;
    logic        i_ocr_wr;
    logic [15:0] i_ocr_data;
    logic [15:0] i_cnt;
    logic        o_cout_pin;
    logic        o_ocm_flg;
    logic [15:0] o_ocr_act;
    logic        o_busy;

    int n_cmp = 0;
    int n_err = 0;

    output_compare_wgen #(.WIDTH(16), .IDLE_LEVEL(1'b0)) dut (
        .i_sysclk   (i_sysclk),
        .i_sysrst   (i_sysrst),
        .i_en       (i_en),
        .i_mode     (i_mode),
        .i_inv      (i_inv),
        .i_force    (i_force),
        .i_ocr_wr   (i_ocr_wr),
        .i_ocr_data (i_ocr_data),
        .i_cnt      (i_cnt),
        .o_cout_pin (o_cout_pin),
        .o_ocm_flg  (o_ocm_flg),
        .o_ocr_act  (o_ocr_act),
        .o_busy     (o_busy)
    );

    always #5 i_sysclk = ~i_sysclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one counter value for one cycle; outputs are sampled 1 ns after the edge.
    task automatic tick(input logic [15:0] c);
        i_cnt = c;
        @(posedge i_sysclk);
        #1;
    endtask

    task automatic ocr_write(input logic [15:0] v, input logic [15:0] c);
        i_ocr_wr   = 1'b1;
        i_ocr_data = v;
        tick(c);
        i_ocr_wr   = 1'b0;
    endtask

    logic        exp_pin;
    int          pulses;
    logic [15:0] seq_max [5];

    initial begin
        seq_max[0] = 16'h0000; seq_max[1] = 16'h0001; seq_max[2] = 16'h0002;
        seq_max[3] = 16'hFFFE; seq_max[4] = 16'hFFFF;

        i_sysrst = 1'b1; i_en = 1'b0; i_mode = 2'b00; i_inv = 1'b0;
        i_force = 1'b0; i_ocr_wr = 1'b0; i_ocr_data = '0; i_cnt = '0;
        tick(0);
        chk("rst_pin", 32'(o_cout_pin), 32'd0);
        chk("rst_flg", 32'(o_ocm_flg), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_ocr", 32'(o_ocr_act), 32'd0);
        i_sysrst = 1'b0;
        tick(0);
        i_inv = 1'b1;
        #1;
        chk("idle_inv_pin", 32'(o_cout_pin), 32'd1);
        i_inv = 1'b0;

        // ---------------- toggle mode, OCR=5 ----------------
        ocr_write(16'd5, 0);
        tick(0);
        chk("m01_ocr_act", 32'(o_ocr_act), 32'd5);
        i_en = 1'b1; i_mode = 2'b01;
        tick(0);
        chk("m01_busy", 32'(o_busy), 32'd1);
        exp_pin = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 10; c++) begin
                tick(16'(c));
                if (c == 5) exp_pin = !exp_pin;
                chk($sformatf("m01_flg_c%0d", c), 32'(o_ocm_flg), 32'(c == 5));
                chk($sformatf("m01_pin_c%0d", c), 32'(o_cout_pin), 32'(exp_pin));
            end
        end
        tick(4);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            tick(5);
            pulses += int'(o_ocm_flg);
        end
        chk("m01_stall_pulses", 32'(pulses), 32'd1);
        chk("m01_stall_pin", 32'(o_cout_pin), 32'd1);

        i_force = 1'b1;
        tick(5);
        i_force = 1'b0;
        chk("force_pin", 32'(o_cout_pin), 32'd0);
        chk("force_flg", 32'(o_ocm_flg), 32'd0);
        tick(4);
        i_force = 1'b1;
        tick(5);
        i_force = 1'b0;
        chk("force_match_pin", 32'(o_cout_pin), 32'd1);
        chk("force_match_flg", 32'(o_ocm_flg), 32'd1);

        // ---------------- async reset mid-run ----------------
        i_sysrst = 1'b1;
        #1;
        chk("arst_pin", 32'(o_cout_pin), 32'd0);
        chk("arst_flg", 32'(o_ocm_flg), 32'd0);
        chk("arst_busy", 32'(o_busy), 32'd0);
        chk("arst_ocr", 32'(o_ocr_act), 32'd0);
        i_en = 1'b0; i_mode = 2'b00;
        tick(0);
        i_sysrst = 1'b0;

        // ---------------- fast PWM, OCR=3, counter 0..7 ----------------
        ocr_write(16'd3, 0);
        tick(0);
        i_en = 1'b1; i_mode = 2'b10;
        tick(0);
        for (int c = 1; c < 8; c++) tick(16'(c));
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 8; c++) begin
                tick(16'(c));
                chk($sformatf("pwm3_pin_c%0d", c), 32'(o_cout_pin), 32'(c < 3));
            end
        for (int c = 0; c < 4; c++) tick(16'(c));
        ocr_write(16'd6, 4);
        for (int c = 5; c < 8; c++) tick(16'(c));
        chk("pwm_ocr_before_bottom", 32'(o_ocr_act), 32'd3);
        for (int c = 0; c < 8; c++) begin
            tick(16'(c));
            chk($sformatf("pwm6_pin_c%0d", c), 32'(o_cout_pin), 32'(c < 6));
        end
        chk("pwm_ocr_after_bottom", 32'(o_ocr_act), 32'd6);

        // OCR=0: one high period through the transfer, then constant low
        tick(0);
        ocr_write(16'd0, 1);
        for (int c = 2; c < 8; c++) tick(16'(c));
        for (int c = 0; c < 8; c++) tick(16'(c));
        chk("pwm0_transfer_pin", 32'(o_cout_pin), 32'd1);
        chk("pwm0_ocr", 32'(o_ocr_act), 32'd0);
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 8; c++) begin
                tick(16'(c));
                chk($sformatf("pwm0_pin_c%0d", c), 32'(o_cout_pin), 32'd0);
            end

        // OCR=MAX: exactly one low count per period
        for (int c = 0; c < 3; c++) tick(16'(c));
        ocr_write(16'hFFFF, 3);
        for (int c = 4; c < 8; c++) tick(16'(c));
        for (int i = 0; i < 5; i++) tick(seq_max[i]);
        chk("pwmmax_ocr", 32'(o_ocr_act), 32'hFFFF);
        for (int p = 0; p < 2; p++) begin
            pulses = 0;
            for (int i = 0; i < 5; i++) begin
                tick(seq_max[i]);
                chk($sformatf("pwmmax_pin_%0h", seq_max[i]), 32'(o_cout_pin), 32'(seq_max[i] != 16'hFFFF));
                pulses += int'(!o_cout_pin);
            end
            chk("pwmmax_low_count", 32'(pulses), 32'd1);
        end

        // ---------------- single-shot, OCR=10 ----------------
        i_en = 1'b0; i_mode = 2'b00;
        tick(0);
        chk("off_pin", 32'(o_cout_pin), 32'd0);
        ocr_write(16'd10, 0);
        tick(0);
        i_en = 1'b1; i_mode = 2'b11;
        tick(0);
        chk("ss_armed_busy", 32'(o_busy), 32'd1);
        for (int c = 1; c < 16; c++) begin
            tick(16'(c));
            chk($sformatf("ss_pin_c%0d", c), 32'(o_cout_pin), 32'(c >= 10));
            chk($sformatf("ss_flg_c%0d", c), 32'(o_ocm_flg), 32'(c == 10));
        end
        chk("ss_done_busy", 32'(o_busy), 32'd0);
        for (int c = 0; c < 13; c++) begin
            tick(16'(c));
            chk($sformatf("ss_hold_pin_c%0d", c), 32'(o_cout_pin), 32'd1);
            chk($sformatf("ss_hold_flg_c%0d", c), 32'(o_ocm_flg), 32'd0);
        end
        i_en = 1'b0;
        tick(13);
        chk("ss_dis_pin", 32'(o_cout_pin), 32'd0);
        i_en = 1'b1;
        tick(14);
        chk("ss_rearm_pin", 32'(o_cout_pin), 32'd0);
        chk("ss_rearm_busy", 32'(o_busy), 32'd1);

        // mode change while enabled: one idle cycle, then the new mode
        i_mode = 2'b01;
        tick(14);
        chk("modechg_idle_busy", 32'(o_busy), 32'd0);
        tick(14);
        chk("modechg_run_busy", 32'(o_busy), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
